pipe_hazard_scoreboard: RTL and testbench
=========================================

PIPE_HAZARD_SCOREBOARD -- requirements
Module: pipe_hazard_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of register values.
REQ-002 SHALL have parameter STAGES, default 3: post-issue stages tracked; stage 0 = EX, stage STAGES-1 = WB.
REQ-003 SHALL have parameter LOAD_READY_STAGE, default 1: first stage index at which load data is valid.
REQ-004 SHALL have parameter SELW, default $clog2(STAGES+1): forward-select width.
REQ-005 SHALL have ports: i_clk input 1, clock; i_reset input 1, reset (synchronous, active-high).
REQ-006 SHALL have ports: i_issue_valid input 1, ID instruction presented; i_issue_wen input 1, it writes rd; i_issue_rd input 5, its rd; i_issue_is_load input 1, it is a load.
REQ-007 SHALL have ports: i_id_rs1, i_id_rs2 input 5, ID source registers; i_rf_data1, i_rf_data2 input WIDTH, register-file read data.
REQ-008 SHALL have ports: i_stage_data input STAGES*WIDTH, result of stage k at bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have ports: i_flush input 1, kill ID instruction; i_stall_ext input 1, freeze whole pipeline.
REQ-010 SHALL have ports: o_stall output 1, hold IF/ID and insert bubble; o_fwd_data1, o_fwd_data2 output WIDTH, resolved operands; o_fwd_sel1, o_fwd_sel2 output SELW, 0 = regfile, k+1 = stage k.
REQ-011 SHALL have ports: o_busy_count output SELW, valid entries; o_stall_cycles output 32, hazard-stall counter.

Function
REQ-012 SHALL keep a STAGES-deep shift register of entries {valid, rd, is_load}.
REQ-013 When i_stall_ext=0, SHALL shift entry[k] <= entry[k-1] on each edge.
REQ-014 Entry[0] SHALL load the ID instruction only if i_issue_valid & i_issue_wen & rd!=0 & !o_stall & !i_flush; otherwise it SHALL load a bubble (valid=0).
REQ-015 When i_stall_ext=1, SHALL hold all entries and counters; i_flush SHALL be ignored that cycle.
REQ-016 For each source rs!=0, the match SHALL be the youngest (lowest k) valid entry with rd==rs; rs==0 SHALL never match and SHALL forward 0 with sel=0.
REQ-017 With no match, SHALL output sel=0 and data=i_rf_data (regfile is not write-through).
REQ-018 o_stall, o_fwd_* SHALL be combinational from entries and inputs; zero-cycle latency.
REQ-019 o_stall SHALL be 0 whenever i_issue_valid=0 or i_flush=1.
REQ-020 o_stall_cycles SHALL increment by 1 on each edge where o_stall=1 and i_stall_ext=0, saturating at 32'hFFFFFFFF.
REQ-021 o_busy_count SHALL equal the number of valid entries.

Reset
REQ-022 On i_reset, SHALL clear all entries to invalid and o_stall_cycles to 0; reset SHALL override i_stall_ext.
REQ-023 After reset, o_stall=0, o_busy_count=0, o_fwd_sel*=0 until the first issue.
REQ-024 Reset mid-stall SHALL drop the stall on the next cycle; no entry survives.

Configuration
REQ-025 Macro SCOREBOARD_FORWARDING_EN SHALL select forwarding.
REQ-026 With SCOREBOARD_FORWARDING_EN defined: on a match at stage k, SHALL forward i_stage_data[k] with sel=k+1; a load match with k<LOAD_READY_STAGE SHALL assert o_stall instead.
REQ-027 Without SCOREBOARD_FORWARDING_EN: any match in any stage SHALL assert o_stall; o_fwd_sel* SHALL be constant 0 and o_fwd_data* SHALL equal i_rf_data*.

Verification
REQ-028 FWD_EN, STAGES=3: issue addi x5 (rd=5); next cycle rs1=5 with stage0 data 0x00000010 -> o_fwd_sel1=1, o_fwd_data1=0x10, o_stall=0.
REQ-029 FWD_EN: issue lw x7; next cycle rs2=7 -> o_stall=1 for exactly 1 cycle; then o_fwd_sel2=2 with stage1 data 0xDEADBEEF; o_stall_cycles=1.
REQ-030 No FWD_EN: issue x3 write, then rs1=3 -> o_stall=1 for 3 consecutive cycles; 4th cycle sel=0, data=i_rf_data1; o_stall_cycles=3.
REQ-031 Issue x9 twice back-to-back (stage1 data 0x1, stage0 data 0x2), then rs1=9 -> youngest wins: sel=1, data=0x2. rs1=0 with an x0 writer -> sel=0, data=0, no stall.
REQ-032 During i_stall_ext=1 for 4 cycles, entries and o_busy_count hold; i_flush during freeze is ignored; after release with i_flush=1, entry[0] is a bubble and o_busy_count drops by the retired count.
REQ-033 Assert i_reset during a load-use stall -> next cycle o_stall=0, o_busy_count=0, o_stall_cycles=0.

Source files
------------

// File: rtl/pipe_hazard_scoreboard.sv
// rtl/pipe_hazard_scoreboard.sv - RAW hazard scoreboard resolving ID operands by stall or forward
// Operand forwarding from post-issue stages is built only when SCOREBOARD_FORWARDING_EN is defined.
module pipe_hazard_scoreboard #(
  parameter int WIDTH            = 32,
  parameter int STAGES           = 3,
  parameter int LOAD_READY_STAGE = 1,
  parameter int SELW             = $clog2(STAGES + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_issue_valid,
  input  logic                    i_issue_wen,
  input  logic [4:0]              i_issue_rd,
  input  logic                    i_issue_is_load,
  input  logic [4:0]              i_id_rs1,
  input  logic [4:0]              i_id_rs2,
  input  logic [WIDTH-1:0]        i_rf_data1,
  input  logic [WIDTH-1:0]        i_rf_data2,
  input  logic [STAGES*WIDTH-1:0] i_stage_data,
  input  logic                    i_flush,
  input  logic                    i_stall_ext,
  output logic                    o_stall,
  output logic [WIDTH-1:0]        o_fwd_data1,
  output logic [WIDTH-1:0]        o_fwd_data2,
  output logic [SELW-1:0]         o_fwd_sel1,
  output logic [SELW-1:0]         o_fwd_sel2,
  output logic [SELW-1:0]         o_busy_count,
  output logic [31:0]             o_stall_cycles
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] load_q, load_d;
  logic [4:0]        rd_q [STAGES];
  logic [4:0]        rd_d [STAGES];
  logic [31:0]       stall_cycles_q, stall_cycles_d;

  logic [4:0]        src_rs   [2];
  logic [WIDTH-1:0]  src_rf   [2];
  logic [1:0]        src_hit;
  logic [1:0]        src_stall;
  logic [SELW-1:0]   src_sel  [2];
  logic [WIDTH-1:0]  src_data [2];
  logic              issue_accept;
  logic [SELW-1:0]   busy;

  assign src_rs[0] = i_id_rs1;
  assign src_rs[1] = i_id_rs2;
  assign src_rf[0] = i_rf_data1;
  assign src_rf[1] = i_rf_data2;

`ifdef SCOREBOARD_FORWARDING_EN
  logic [1:0]        src_early_load;
  logic [SELW-1:0]   src_hit_sel  [2];
  logic [WIDTH-1:0]  src_hit_data [2];
`else
  logic              unused_fwd_inputs;
  assign unused_fwd_inputs = ^{i_stage_data, load_q, (LOAD_READY_STAGE > 0)};
`endif

  // Scan oldest to youngest so the last hit recorded is the youngest producer.
  always_comb begin
    src_hit = '0;
`ifdef SCOREBOARD_FORWARDING_EN
    src_early_load = '0;
    for (int s = 0; s < 2; s++) begin
      src_hit_sel[s]  = '0;
      src_hit_data[s] = '0;
    end
`endif
    for (int s = 0; s < 2; s++) begin
      for (int k = STAGES - 1; k >= 0; k--) begin
        if (valid_q[k] && (rd_q[k] == src_rs[s]) && (src_rs[s] != 5'd0)) begin
          src_hit[s] = 1'b1;
`ifdef SCOREBOARD_FORWARDING_EN
          src_early_load[s] = load_q[k] && (k < LOAD_READY_STAGE);
          src_hit_sel[s]    = SELW'(k + 1);
          src_hit_data[s]   = i_stage_data[k*WIDTH +: WIDTH];
`endif
        end
      end
    end
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      src_stall[s] = 1'b0;
      src_sel[s]   = '0;
      src_data[s]  = src_rf[s];
`ifdef SCOREBOARD_FORWARDING_EN
      src_stall[s] = src_early_load[s];
      if (src_rs[s] == 5'd0) begin
        src_data[s] = '0;
      end else if (src_hit[s] && !src_early_load[s]) begin
        src_sel[s]  = src_hit_sel[s];
        src_data[s] = src_hit_data[s];
      end
`else
      src_stall[s] = src_hit[s];
`endif
    end
  end

  assign o_stall     = i_issue_valid && !i_flush && (|src_stall);
  assign o_fwd_sel1  = src_sel[0];
  assign o_fwd_sel2  = src_sel[1];
  assign o_fwd_data1 = src_data[0];
  assign o_fwd_data2 = src_data[1];

  // A stalled or flushed instruction enters EX as a bubble; x0 writers are never tracked.
  assign issue_accept = i_issue_valid && i_issue_wen && (i_issue_rd != 5'd0) &&
                        !o_stall && !i_flush;

  always_comb begin
    busy = '0;
    for (int k = 0; k < STAGES; k++) begin
      busy = busy + SELW'(valid_q[k]);
    end
  end

  assign o_busy_count   = busy;
  assign o_stall_cycles = stall_cycles_q;

  always_comb begin
    valid_d        = valid_q;
    load_d         = load_q;
    rd_d           = rd_q;
    stall_cycles_d = stall_cycles_q;
    if (!i_stall_ext) begin
      for (int k = STAGES - 1; k > 0; k--) begin
        valid_d[k] = valid_q[k-1];
        load_d[k]  = load_q[k-1];
        rd_d[k]    = rd_q[k-1];
      end
      valid_d[0] = issue_accept;
      load_d[0]  = i_issue_is_load;
      rd_d[0]    = i_issue_rd;
      if (o_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_d = stall_cycles_q + 32'd1;
      end
    end
    if (i_reset) begin
      valid_d        = '0;
      load_d         = '0;
      stall_cycles_d = '0;
      for (int k = 0; k < STAGES; k++) begin
        rd_d[k] = 5'd0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    valid_q        <= valid_d;
    load_q         <= load_d;
    rd_q           <= rd_d;
    stall_cycles_q <= stall_cycles_d;
  end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb/tb_pipe_hazard_scoreboard.sv - directed and randomized checks of pipe_hazard_scoreboard
module tb_pipe_hazard_scoreboard;

  localparam int WIDTH = 32;
  localparam int STAGES = 3;
  localparam int LRS = 1;
  localparam int SELW = $clog2(STAGES + 1);

  logic                    clk;
  logic                    i_reset;
  logic                    i_issue_valid;
  logic                    i_issue_wen;
  logic [4:0]              i_issue_rd;
  logic                    i_issue_is_load;
  logic [4:0]              i_id_rs1;
  logic [4:0]              i_id_rs2;
  logic [WIDTH-1:0]        i_rf_data1;
  logic [WIDTH-1:0]        i_rf_data2;
  logic [STAGES*WIDTH-1:0] i_stage_data;
  logic                    i_flush;
  logic                    i_stall_ext;
  logic                    o_stall;
  logic [WIDTH-1:0]        o_fwd_data1;
  logic [WIDTH-1:0]        o_fwd_data2;
  logic [SELW-1:0]         o_fwd_sel1;
  logic [SELW-1:0]         o_fwd_sel2;
  logic [SELW-1:0]         o_busy_count;
  logic [31:0]             o_stall_cycles;

  pipe_hazard_scoreboard #(
    .WIDTH(WIDTH), .STAGES(STAGES), .LOAD_READY_STAGE(LRS), .SELW(SELW)
  ) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_issue_valid(i_issue_valid), .i_issue_wen(i_issue_wen),
    .i_issue_rd(i_issue_rd), .i_issue_is_load(i_issue_is_load),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
    .i_rf_data1(i_rf_data1), .i_rf_data2(i_rf_data2),
    .i_stage_data(i_stage_data), .i_flush(i_flush), .i_stall_ext(i_stall_ext),
    .o_stall(o_stall), .o_fwd_data1(o_fwd_data1), .o_fwd_data2(o_fwd_data2),
    .o_fwd_sel1(o_fwd_sel1), .o_fwd_sel2(o_fwd_sel2),
    .o_busy_count(o_busy_count), .o_stall_cycles(o_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       ld;
  } ent_t;

  ent_t            m_q[$];
  longint unsigned m_cycles;
  int              n_checks;
  int              n_fails;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ent_t e;
    e.v = 1'b0;
    e.rd = 5'd0;
    e.ld = 1'b0;
    m_q.delete();
    for (int i = 0; i < STAGES; i++) m_q.push_back(e);
    m_cycles = 0;
  endtask

  function automatic int youngest(input bit [4:0] rs);
    for (int a = 0; a < m_q.size(); a++) begin
      if (m_q[a].v && (m_q[a].rd == rs) && (rs != 5'd0)) return a;
    end
    return -1;
  endfunction

  function automatic logic [STAGES*WIDTH-1:0] rand_sd();
    logic [STAGES*WIDTH-1:0] r;
    for (int i = 0; i < STAGES; i++) r[i*WIDTH +: WIDTH] = $urandom;
    return r;
  endfunction

  // One clock: drive at negedge, check outputs against the model, then advance the model.
  task automatic cycle(input bit rst, input bit stx, input bit fl, input bit v, input bit wen,
                       input bit [4:0] rd, input bit ld, input bit [4:0] rs1, input bit [4:0] rs2,
                       input logic [STAGES*WIDTH-1:0] sd,
                       input logic [WIDTH-1:0] rf1, input logic [WIDTH-1:0] rf2);
    bit [4:0]         rs [2];
    logic [WIDTH-1:0] rf [2];
    bit               s_stall [2];
    bit               chk [2];
    logic [SELW-1:0]  e_sel [2];
    logic [WIDTH-1:0] e_data [2];
    bit               e_stall;
    int               a;
    int               busy;
    ent_t             ne;
    @(negedge clk);
    rs[0] = rs1;
    rs[1] = rs2;
    rf[0] = (rs1 == 5'd0) ? '0 : rf1;
    rf[1] = (rs2 == 5'd0) ? '0 : rf2;
    i_reset = rst; i_stall_ext = stx; i_flush = fl;
    i_issue_valid = v; i_issue_wen = wen; i_issue_rd = rd; i_issue_is_load = ld;
    i_id_rs1 = rs1; i_id_rs2 = rs2; i_rf_data1 = rf[0]; i_rf_data2 = rf[1];
    i_stage_data = sd;
    #1;
    for (int s = 0; s < 2; s++) begin
      a = youngest(rs[s]);
      e_sel[s] = '0;
      e_data[s] = rf[s];
      s_stall[s] = 1'b0;
      chk[s] = 1'b1;
`ifdef SCOREBOARD_FORWARDING_EN
      if (rs[s] == 5'd0) e_data[s] = '0;
      else if (a >= 0 && m_q[a].ld && a < LRS) s_stall[s] = 1'b1;
      else if (a >= 0) begin
        e_sel[s] = SELW'(a + 1);
        e_data[s] = sd[a*WIDTH +: WIDTH];
      end
      chk[s] = !s_stall[s];
`else
      s_stall[s] = (a >= 0);
`endif
    end
    e_stall = v && !fl && (s_stall[0] || s_stall[1]);
    busy = 0;
    foreach (m_q[i]) busy += int'(m_q[i].v);
    check_eq("stall", o_stall, e_stall);
    if (chk[0]) begin
      check_eq("sel1", o_fwd_sel1, e_sel[0]);
      check_eq("data1", o_fwd_data1, e_data[0]);
    end
    if (chk[1]) begin
      check_eq("sel2", o_fwd_sel2, e_sel[1]);
      check_eq("data2", o_fwd_data2, e_data[1]);
    end
    check_eq("busy", o_busy_count, busy);
    check_eq("stall_cycles", o_stall_cycles, m_cycles);
    if (rst) model_reset();
    else if (!stx) begin
      if (e_stall && m_cycles < 64'hFFFF_FFFF) m_cycles++;
      ne.v = v && wen && (rd != 5'd0) && !e_stall && !fl;
      ne.rd = rd;
      ne.ld = ld;
      m_q.push_front(ne);
      void'(m_q.pop_back());
    end
  endtask

  task automatic op(input bit rst, input bit stx, input bit fl, input bit v,
                    input bit [4:0] rd, input bit ld, input bit [4:0] rs1, input bit [4:0] rs2);
    cycle(rst, stx, fl, v, 1'b1, rd, ld, rs1, rs2, rand_sd(), $urandom, $urandom);
  endtask

  initial begin
    n_checks = 0;
    n_fails = 0;
    i_reset = 1'b1; i_stall_ext = 1'b0; i_flush = 1'b0;
    i_issue_valid = 1'b0; i_issue_wen = 1'b0; i_issue_rd = '0; i_issue_is_load = 1'b0;
    i_id_rs1 = '0; i_id_rs2 = '0; i_rf_data1 = '0; i_rf_data2 = '0; i_stage_data = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state
    op(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("rst_stall", o_stall, 0);
    check_eq("rst_busy", o_busy_count, 0);
    check_eq("rst_sel1", o_fwd_sel1, 0);
    check_eq("rst_cycles", o_stall_cycles, 0);

    // Dependent ALU op on x3
    op(1, 0, 0, 0, 0, 0, 0, 0);
    op(0, 0, 0, 1, 3, 0, 0, 0);
`ifdef SCOREBOARD_FORWARDING_EN
    op(0, 0, 0, 1, 10, 0, 3, 0);
    check_eq("alu_fwd_nostall", o_stall, 0);
    check_eq("alu_fwd_sel", o_fwd_sel1, 1);
`else
    for (int i = 0; i < 3; i++) begin
      op(0, 0, 0, 1, 10, 0, 3, 0);
      check_eq("raw_stall", o_stall, 1);
    end
    cycle(0, 0, 0, 1, 1, 10, 0, 3, 0, rand_sd(), 32'h1234_5678, 32'h0);
    check_eq("raw_release_stall", o_stall, 0);
    check_eq("raw_release_sel", o_fwd_sel1, 0);
    check_eq("raw_release_data", o_fwd_data1, 32'h1234_5678);
    check_eq("raw_cycles", o_stall_cycles, 3);
`endif

    // Two writers of x9: the younger one must win
    op(1, 0, 0, 0, 0, 0, 0, 0);
    op(0, 0, 0, 1, 9, 0, 0, 0);
    op(0, 0, 0, 1, 9, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 11, 0, 9, 0, {32'h0, 32'h1, 32'h2}, 32'hAAAA_0000, 32'h0);
`ifdef SCOREBOARD_FORWARDING_EN
    check_eq("youngest_sel", o_fwd_sel1, 1);
    check_eq("youngest_data", o_fwd_data1, 32'h2);
`else
    check_eq("youngest_stall", o_stall, 1);
`endif
    op(0, 0, 0, 1, 0, 0, 0, 0);
    op(0, 0, 0, 1, 12, 0, 0, 0);
    check_eq("x0_stall", o_stall, 0);
    check_eq("x0_sel", o_fwd_sel1, 0);
    check_eq("x0_data", o_fwd_data1, 0);

    // External freeze with flush ignored, then release with flush
    op(1, 0, 0, 0, 0, 0, 0, 0);
    op(0, 0, 0, 1, 4, 0, 0, 0);
    op(0, 0, 0, 1, 5, 0, 0, 0);
    op(0, 0, 0, 1, 6, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      op(0, 1, 1, 1, 7, 0, 0, 0);
      check_eq("freeze_busy", o_busy_count, 3);
    end
    op(0, 0, 1, 1, 8, 0, 0, 0);
    op(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("flush_busy", o_busy_count, 2);

`ifdef SCOREBOARD_FORWARDING_EN
    // Load-use: one bubble, then forward from stage 1
    op(1, 0, 0, 0, 0, 0, 0, 0);
    op(0, 0, 0, 1, 7, 1, 0, 0);
    op(0, 0, 0, 1, 13, 0, 0, 7);
    check_eq("lu_stall", o_stall, 1);
    cycle(0, 0, 0, 1, 1, 13, 0, 0, 7, {32'h0, 32'hDEAD_BEEF, 32'h5}, 32'h0, 32'h77);
    check_eq("lu_release", o_stall, 0);
    check_eq("lu_sel", o_fwd_sel2, 2);
    check_eq("lu_data", o_fwd_data2, 32'hDEAD_BEEF);
    check_eq("lu_cycles", o_stall_cycles, 1);
`endif

    // Reset during a load-use stall
    op(1, 0, 0, 0, 0, 0, 0, 0);
    op(0, 0, 0, 1, 7, 1, 0, 0);
    op(1, 0, 0, 1, 13, 0, 0, 7);
    check_eq("rst_mid_stall_before", o_stall, 1);
    op(0, 0, 0, 1, 13, 0, 0, 7);
    check_eq("rst_mid_stall", o_stall, 0);
    check_eq("rst_mid_busy", o_busy_count, 0);
    check_eq("rst_mid_cycles", o_stall_cycles, 0);

    // Randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 800; n++) begin
      cycle(($urandom % 97) == 0, ($urandom % 8) == 0, ($urandom % 8) == 0,
            ($urandom % 4) != 0, ($urandom % 4) != 0, 5'($urandom % 8), ($urandom % 3) == 0,
            5'($urandom % 8), 5'($urandom % 8), rand_sd(), $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
